// File: rtl/bless_inject_ctrl_pkg.sv
// Shared definitions for the BLESS local-port injection controller:
// flit geometry, router port count and injection FSM encodings.
package bless_inject_ctrl_pkg;

  localparam int WIDTH_INTERNAL = 32;
  localparam int POS_X_DST      = 0;
  localparam int POS_Y_DST      = 4;
  localparam int POS_W          = 4;
  localparam int NUM_PORT       = 5;
  localparam int STARVE_CNT_W   = 8;

  typedef enum logic [1:0] {
    INJ_IDLE    = 2'd0,
    INJ_WAIT    = 2'd1,
    INJ_STARVED = 2'd2
  } inj_state_e;

  function automatic logic [WIDTH_INTERNAL-1:0] make_flit(
    input logic [POS_W-1:0] dst_x,
    input logic [POS_W-1:0] dst_y,
    input logic [WIDTH_INTERNAL-1:0] payload
  );
    logic [WIDTH_INTERNAL-1:0] f;
    f = payload;
    f[POS_X_DST +: POS_W] = dst_x;
    f[POS_Y_DST +: POS_W] = dst_y;
    return f;
  endfunction

endpackage

// File: rtl/bless_inject_ctrl_fifo.sv
// inj_fifo: first-word-fall-through FIFO with exact fill count.
// A push while full is legal only together with a pop in the same cycle.
module inj_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     dout_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push_i && pop_i) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read path is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bless_inject_ctrl.sv
// Local-port injection controller for the BLESS router: buffers PE flits and
// injects when a router output is free. Optional throttle: BLESS_INJ_THROTTLE_EN.
module bless_inject_ctrl
  import bless_inject_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int STARVE_TH = 16
`ifdef BLESS_INJ_THROTTLE_EN
  ,
  parameter int INJ_GAP   = 4
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH_INTERNAL-1:0] pe_flit,
  input  logic                      pe_valid,
  output logic                      pe_ready,
  input  logic [3:0]                net_valid,
  output logic [WIDTH_INTERNAL-1:0] inj_flit,
  output logic                      inj_valid,
  output logic                      starve,
  output logic [PTR_W:0]            occupancy
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LAST = STARVE_CNT_W'(STARVE_TH - 1);

  inj_state_e               state_q, state_d;
  logic [STARVE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH_INTERNAL-1:0] head;
  logic                     empty, full;
  logic                     slot_free, gap_ok, push, pop;

  assign slot_free = ($countones(net_valid) < (NUM_PORT - 1));
  assign pop       = !empty && slot_free && gap_ok;
  assign push      = pe_valid && pe_ready;
  assign pe_ready  = !full || pop;
  assign inj_valid = pop;
  assign inj_flit  = pop ? head : '0;
  assign starve    = (state_q == INJ_STARVED);

  inj_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (WIDTH_INTERNAL)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (pe_flit),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (occupancy),
    .empty_o (empty),
    .full_o  (full)
  );

`ifdef BLESS_INJ_THROTTLE_EN
  localparam int GAP_W = 8;
  logic [GAP_W-1:0] gap_q, gap_d;

  assign gap_ok = (gap_q == '0);

  always_comb begin
    gap_d = gap_q;
    if (pop)               gap_d = GAP_W'(INJ_GAP - 1);
    else if (gap_q != '0)  gap_d = gap_q - GAP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign gap_ok = 1'b1;
`endif

  // A pop that takes the last entry only returns to IDLE if nothing refills it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INJ_IDLE: begin
        cnt_d = '0;
        if (push) state_d = INJ_WAIT;
      end
      INJ_WAIT: begin
        if (pop) begin
          cnt_d = '0;
          if (occupancy == (PTR_W+1)'(1) && !push) state_d = INJ_IDLE;
        end else if (!empty) begin
          if (cnt_q == STARVE_LAST) state_d = INJ_STARVED;
          else                      cnt_d   = cnt_q + STARVE_CNT_W'(1);
        end
      end
      INJ_STARVED: begin
        if (pop) begin
          cnt_d   = '0;
          state_d = (occupancy == (PTR_W+1)'(1) && !push) ? INJ_IDLE : INJ_WAIT;
        end
      end
      default: begin
        state_d = INJ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INJ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
